// File: rtl/del_sched_pkg.sv
// Shared types and defaults for the del_sched delay-unit scheduler.
package del_sched_pkg;

  localparam int N_REQ_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TO_CYCLES_DEF   = 255;
  localparam int ST_W            = 3;
  localparam int CNT_W           = 16;

  typedef enum logic [ST_W-1:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    RELEASE = 3'd2,
    ACK     = 3'd3,
    ERR     = 3'd4
  } state_e;

endpackage

// File: rtl/del_sched_rr.sv
// Round-robin picker: first set req bit at or after ptr, wrapping modulo N_REQ.
module del_sched_rr #(
  parameter int  N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate back to ptr so the closest one wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % N_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/del_sched.sv
// Round-robin scheduler sharing one asynchronous delay unit among N_REQ requesters.
// Optional LAUNCH/RELEASE timeout with ERR state is enabled by DEL_SCHED_TIMEOUT_EN.
module del_sched
  import del_sched_pkg::*;
#(
  parameter int  N_REQ       = N_REQ_DEF,
  parameter int  SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int  TO_CYCLES   = TO_CYCLES_DEF,
  localparam int IDX_W       = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic             del_req,
  input  logic             del_done,
  output logic [IDX_W-1:0] grant_id,
  output logic             busy,
  output logic             to_err
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       gnt_q, gnt_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   armed_q, armed_d;
  logic                   done_s;
  logic                   rr_valid;
  logic [IDX_W-1:0]       rr_index;
  logic                   to_hit;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(N_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  del_sched_rr #(.N_REQ(N_REQ)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .valid (rr_valid),
    .index (rr_index)
  );

  assign done_s = sync_q[SYNC_STAGES-1];

`ifdef DEL_SCHED_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero in IDLE so it starts from zero on entering LAUNCH.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)
      cnt_d = '0;
    else if (state_q == LAUNCH || state_q == RELEASE)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign to_hit = (cnt_q == CNT_W'(TO_CYCLES - 1));
  assign to_err = (state_q == ERR);
`else
  logic unused_to_cfg;
  assign unused_to_cfg = (TO_CYCLES != 0);
  assign to_hit        = 1'b0;
  assign to_err        = 1'b0;
`endif

  // armed_q blocks a grant on the first edge after reset release.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], del_done};
    armed_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      sync_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      sync_q  <= sync_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (armed_q && rr_valid) begin
          state_d = LAUNCH;
          gnt_d   = rr_index;
        end
      end
      LAUNCH: begin
        if (to_hit)      state_d = ERR;
        else if (done_s) state_d = RELEASE;
      end
      RELEASE: begin
        if (to_hit)       state_d = ERR;
        else if (!done_s) state_d = ACK;
      end
      ACK, ERR: begin
        // An owner that already dropped req leaves here on the first cycle.
        if (!req[gnt_q]) begin
          state_d = IDLE;
          ptr_d   = ptr_after(gnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack      = '0;
    del_req  = 1'b0;
    busy     = (state_q != IDLE);
    grant_id = gnt_q;
    case (state_q)
      LAUNCH:   del_req = 1'b1;
      ACK, ERR: ack[gnt_q] = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_del_sched.sv
// Directed bench for del_sched with a behavioural scoreboard checked every cycle.
module tb_del_sched;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       del_done = 1'b0;
  logic [3:0] ack;
  logic       del_req;
  logic [1:0] grant_id;
  logic       busy;
  logic       to_err;

  int checks = 0;
  int errors = 0;
  int n_rst  = 0;

  // delay-unit model state, owned by the stimulus process
  logic [7:0] hist = 8'b0;
  int         dly = 5;
  bit         stuck = 1'b0;

  del_sched #(.N_REQ(N), .SYNC_STAGES(S), .TO_CYCLES(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ack      (ack),
    .del_req  (del_req),
    .del_done (del_done),
    .grant_id (grant_id),
    .busy     (busy),
    .to_err   (to_err)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (((r >> ((p + i) % N)) & 4'b1) != 4'b0) return (p + i) % N;
    return -1;
  endfunction

  // ---------------- scoreboard ----------------
  int         c_seen = 0, rel = 0, c_cyc = 0;
  int         m_ptr = 0, m_gnt = 0;
  int         t_rise = 0, t_drise = 0, t_dfall = 0;
  bit         saw_done = 1'b0;
  logic [3:0] p_req = 4'b0, p_ack = 4'b0;
  logic       p_busy = 1'b0, p_dreq = 1'b0, p_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n || n_rst != c_seen) begin
      c_seen   = n_rst;
      rel      = 0;
      m_ptr    = 0;
      saw_done = 1'b0;
    end else begin
      rel++;
      chk_eq("ack_onehot", int'($countones(ack) <= 1), 1);
      chk_eq("dreq_ack_excl", int'(del_req && (ack != 4'b0)), 0);
      if (del_req || ack != 4'b0) chk_eq("busy_active", busy, 1);
`ifndef DEL_SCHED_TIMEOUT_EN
      chk_eq("to_err_zero", to_err, 0);
`endif
      if (rel == 1) begin
        chk_eq("no_start_first_edge", del_req, 0);
      end else if (!p_busy && p_req != 4'b0) begin
        m_gnt = rr_pick(p_req, m_ptr);
        chk_eq("idle_launch", del_req, 1);
        chk_eq("rr_grant", grant_id, m_gnt);
        saw_done = 1'b0;
        t_rise   = c_cyc;
      end
      if (del_done && !p_done) begin t_drise = c_cyc; saw_done = 1'b1; end
      if (!del_done && p_done) t_dfall = c_cyc;
      if (p_busy && busy) chk_eq("grant_stable", grant_id, m_gnt);
      if (p_dreq && !del_req) begin
        if (saw_done) chk_eq("launch_exit_lat", c_cyc - t_drise, S + 1);
        else          chk_eq("timeout_lat", c_cyc - t_rise, TO);
      end
      if (p_ack == 4'b0 && ack != 4'b0) begin
        chk_eq("ack_owner", ack, 1 << m_gnt);
        chk_eq("to_err_flag", to_err, int'(!saw_done));
        if (saw_done) chk_eq("release_exit_lat", c_cyc - t_dfall, S + 1);
      end
      if (p_ack != 4'b0) begin
        if (((p_req >> m_gnt) & 4'b1) == 4'b0) begin
          chk_eq("ack_drop", ack, 0);
          chk_eq("ack_drop_idle", busy, 0);
          m_ptr = (m_gnt + 1) % N;
        end else begin
          chk_eq("ack_hold", ack, p_ack);
        end
      end
    end
    p_req  = req;
    p_ack  = ack;
    p_busy = busy;
    p_dreq = del_req;
    p_done = del_done;
    c_cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (stuck) begin
      del_done = 1'b0;
    end else begin
      hist     = {hist[6:0], del_req};
      del_done = hist[3'(dly - 1)];
    end
  endtask

  task automatic wait_ack(input int g, input string nm);
    int n = 0;
    while (ack == 4'b0 && n < 100) begin tick(); n++; end
    chk_eq(nm, ack, 1 << g);
  endtask

  task automatic wait_launch(input int g, input string nm);
    int n = 0;
    while (!del_req && n < 20) begin tick(); n++; end
    chk_eq(nm, grant_id, g);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  initial begin
    int n, fall_n;
    repeat (3) tick();
    chk_eq("rst_del_req", del_req, 0);
    chk_eq("rst_ack", ack, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_grant", grant_id, 0);
    chk_eq("rst_to_err", to_err, 0);
    rst_n = 1'b1;
    n_rst++;
    repeat (3) tick();

    // single request from requester 2, 5-cycle echo
    dly = 5;
    req = 4'b0100;
    tick();
    chk_eq("t033_dreq_rise", del_req, 1);
    chk_eq("t033_grant", grant_id, 2);
    n = 0; fall_n = -1;
    while (ack == 4'b0 && n < 60) begin
      tick(); n++;
      if (!del_req && fall_n < 0) fall_n = n;
    end
    chk_eq("t033_dreq_width", fall_n, 7);
    chk_eq("t033_ack_lat", n, 14);
    chk_eq("t033_ack", ack, 4'b0100);
    chk_eq("t033_to_err", to_err, 0);
    req = 4'b0;
    tick();
    chk_eq("t033_ack_off", ack, 0);
    chk_eq("t033_idle", busy, 0);

    // wrap from ptr=3
    req = 4'b1001;
    tick();
    chk_eq("t035_first", grant_id, 3);
    wait_ack(3, "t035_ack3");
    req = 4'b0001;
    tick();
    wait_launch(0, "t035_wrap");
    wait_ack(0, "t035_ack0");
    req = 4'b0;
    tick();

    // reset while in RELEASE
    dly = 3;
    req = 4'b1000;
    tick();
    chk_eq("t037_grant", grant_id, 3);
    n = 0;
    while (del_req && n < 100) begin tick(); n++; end
    #1 rst_n = 1'b0;
    #1;
    chk_eq("t037_dreq", del_req, 0);
    chk_eq("t037_ack", ack, 0);
    chk_eq("t037_busy", busy, 0);
    chk_eq("t037_grant0", grant_id, 0);
    hist = 8'b0; del_done = 1'b0;
    req = 4'b1111;
    #1 rst_n = 1'b1;
    n_rst++;
    tick();
    chk_eq("t037_no_start", del_req, 0);
    tick();
    chk_eq("t037_restart", del_req, 1);
    chk_eq("t037_ptr0", grant_id, 0);

    // all requesters held: 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      if (k > 0) wait_launch(k % N, "t034_order");
      wait_ack(k % N, "t034_ack");
      req = req & ~(4'b0001 << (k % N));
      tick();
      chk_eq("t034_ack_off", ack, 0);
      if (k < 4) req = req | (4'b0001 << (k % N));
      else       req = 4'b0;
    end

    // owner withdraws during LAUNCH
    req = 4'b0110;
    tick();
    chk_eq("t038_grant", grant_id, 1);
    req = 4'b0100;
    wait_ack(1, "t038_ack");
    tick();
    chk_eq("t038_ack_1cyc", ack, 0);
    wait_launch(2, "t038_next");
    wait_ack(2, "t038_ack2");
    req = 4'b0;
    tick();

`ifdef DEL_SCHED_TIMEOUT_EN
    stuck = 1'b1;
    req = 4'b0001;
    tick();
    chk_eq("t036_grant", grant_id, 0);
    n = 0;
    while (del_req && n < 100) begin tick(); n++; end
    chk_eq("t036_dreq_width", n, TO);
    chk_eq("t036_ack", ack, 4'b0001);
    chk_eq("t036_to_err", to_err, 1);
    req = 4'b0;
    tick();
    chk_eq("t036_ack_off", ack, 0);
    chk_eq("t036_to_err_off", to_err, 0);
    stuck = 1'b0;
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
